// File: rtl/alu_pkg.sv
// Shared definitions for the tiny tensor core ALU and its dot-product sequencer.
package alu_pkg;

    localparam int ALU_BUS_WIDTH = 8;

    localparam logic [7:0] ALU_OP_ADD = 8'h00;
    localparam logic [7:0] ALU_OP_SUB = 8'h01;
    localparam logic [7:0] ALU_OP_MUL = 8'h02;
    localparam logic [7:0] ALU_OP_EQ  = 8'h03;
    localparam logic [7:0] ALU_OP_GT  = 8'h04;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MUL   = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } dot_state_t;

endpackage

// File: rtl/alu_dot_sequencer.sv
// Streams element pairs through the shared combinational ALU (MUL then ADD)
// and accumulates a wrap-around dot product, offered on a valid/ready port.
module alu_dot_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = ALU_BUS_WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   enable_in,
    input  logic [DATA_WIDTH-1:0]  a_in,
    input  logic [DATA_WIDTH-1:0]  b_in,
    input  logic                   in_valid_in,
    input  logic                   in_last_in,
    output logic                   in_ready_out,
    output logic [7:0]             alu_opcode_out,
    output logic [DATA_WIDTH-1:0]  alu_input1_out,
    output logic [DATA_WIDTH-1:0]  alu_input2_out,
    input  logic [DATA_WIDTH-1:0]  alu_result_in,
    output logic [DATA_WIDTH-1:0]  result_out,
    output logic [COUNT_WIDTH-1:0] result_count_out,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output dot_state_t             dbg_state_out
);

    // Handshakes: a transfer happens on a rising edge where valid && ready
    // (and enable_in) are high; ready/valid are decoded from registered state only.

    dot_state_t             r_state;
    dot_state_t             w_next_state;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_b;
    logic                   r_last;
    logic [DATA_WIDTH-1:0]  r_prod;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= S_FETCH;
        end else if (enable_in) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: if (in_valid_in) w_next_state = S_MUL;
            S_MUL:   w_next_state = S_ADD;
            S_ADD:   w_next_state = r_last ? S_DONE : S_FETCH;
            S_DONE:  if (result_ready_in) w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        in_ready_out     = 1'b0;
        result_valid_out = 1'b0;
        alu_opcode_out   = ALU_OP_ADD;
        alu_input1_out   = '0;
        alu_input2_out   = '0;
        case (r_state)
            S_FETCH: in_ready_out = enable_in;
            S_MUL: begin
                alu_opcode_out = ALU_OP_MUL;
                alu_input1_out = r_a;
                alu_input2_out = r_b;
            end
            S_ADD: begin
                alu_opcode_out = ALU_OP_ADD;
                alu_input1_out = r_acc;
                alu_input2_out = r_prod;
            end
            S_DONE:  result_valid_out = 1'b1;
            default: ;
        endcase
    end

    // The ALU is combinational, so its result is captured on the edge leaving MUL/ADD.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_last  <= 1'b0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (enable_in) begin
            case (r_state)
                S_FETCH: begin
                    if (in_valid_in) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_last <= in_last_in;
                    end
                end
                S_MUL: r_prod <= alu_result_in;
                S_ADD: begin
                    r_acc   <= alu_result_in;
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
                S_DONE: begin
                    if (result_ready_in) begin
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_out       = r_acc;
    assign result_count_out = r_count;
    assign dbg_state_out    = r_state;

endmodule

// File: tb/tb_alu_dot_sequencer.sv
// Bench for alu_dot_sequencer with a behavioural ALU closing the loop.
module tb_alu_dot_sequencer;
    import alu_pkg::*;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       enable_in = 1'b1;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       in_valid_in = 1'b0;
    logic       in_last_in = 1'b0;
    logic       in_ready_out;
    logic [7:0] alu_opcode_out;
    logic [7:0] alu_input1_out;
    logic [7:0] alu_input2_out;
    logic [7:0] alu_result_in;
    logic [7:0] result_out;
    logic [7:0] result_count_out;
    logic       result_valid_out;
    logic       result_ready_in = 1'b0;
    dot_state_t dbg_state_out;

    alu_dot_sequencer #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
        .a_in(a_in), .b_in(b_in), .in_valid_in(in_valid_in), .in_last_in(in_last_in),
        .in_ready_out(in_ready_out), .alu_opcode_out(alu_opcode_out),
        .alu_input1_out(alu_input1_out), .alu_input2_out(alu_input2_out),
        .alu_result_in(alu_result_in), .result_out(result_out),
        .result_count_out(result_count_out), .result_valid_out(result_valid_out),
        .result_ready_in(result_ready_in), .dbg_state_out(dbg_state_out)
    );

    // Clock / reset
    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    // Behavioural 8-bit ALU
    always_comb begin
        alu_result_in = 8'h00;
        case (alu_opcode_out)
            ALU_OP_ADD: alu_result_in = alu_input1_out + alu_input2_out;
            ALU_OP_SUB: alu_result_in = alu_input1_out - alu_input2_out;
            ALU_OP_MUL: alu_result_in = 8'(alu_input1_out * alu_input2_out);
            default:    alu_result_in = 8'h00;
        endcase
    end

    // Scoreboard
    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int accept_cyc = 0;

    typedef struct {
        int         n;
        logic [7:0] a[4];
        logic [7:0] b[4];
        logic [7:0] exp_res;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: present a pair and hold it until the edge that accepts it.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        int guard = 0;
        a_in = a; b_in = b; in_last_in = last; in_valid_in = 1'b1;
        while (!in_ready_out && guard < 100) begin
            @(negedge clock_in);
            guard++;
        end
        if (!in_ready_out) check("send_pair ready timeout", in_ready_out, 1);
        @(posedge clock_in);
        accept_cyc = cyc;
        #1;
        in_valid_in = 1'b0; in_last_in = 1'b0;
    endtask

    task automatic send_vector(input vec_t v);
        exp_q.push_back({v.exp_cnt, v.exp_res});
        for (int i = 0; i < v.n; i++) send_pair(v.a[i], v.b[i], i == v.n - 1);
    endtask

    // Monitor: wait for a result, compare with the head of the queue, consume it.
    task automatic collect(input string name);
        int guard = 0;
        logic [15:0] e;
        while (!result_valid_out && guard < 100) begin
            @(negedge clock_in);
            guard++;
        end
        if (!result_valid_out) begin
            check({name, " valid timeout"}, result_valid_out, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, " unexpected result"}, exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check({name, " result"}, result_out, e[7:0]);
        check({name, " count"}, result_count_out, e[15:8]);
        result_ready_in = 1'b1;
        @(posedge clock_in);
        #1;
        result_ready_in = 1'b0;
        check({name, " ready after handshake"}, in_ready_out, 1);
        check({name, " valid drops"}, result_valid_out, 0);
    endtask

    initial begin
        int first_acc;
        logic [7:0] hold_res;
        logic [7:0] model_acc;
        logic [7:0] ra, rb;
        vec_t rv;

        vecs[0].n = 2; vecs[0].a = '{2, 4, 0, 0};   vecs[0].b = '{3, 5, 0, 0};
        vecs[0].exp_res = 8'd26;  vecs[0].exp_cnt = 8'd2;
        vecs[1].n = 1; vecs[1].a = '{16, 0, 0, 0};  vecs[1].b = '{16, 0, 0, 0};
        vecs[1].exp_res = 8'd0;   vecs[1].exp_cnt = 8'd1;
        vecs[2].n = 2; vecs[2].a = '{200, 100, 0, 0}; vecs[2].b = '{2, 1, 0, 0};
        vecs[2].exp_res = 8'd244; vecs[2].exp_cnt = 8'd2;
        vecs[3].n = 1; vecs[3].a = '{7, 0, 0, 0};   vecs[3].b = '{9, 0, 0, 0};
        vecs[3].exp_res = 8'd63;  vecs[3].exp_cnt = 8'd1;
        vecs[4].n = 1; vecs[4].a = '{1, 0, 0, 0};   vecs[4].b = '{1, 0, 0, 0};
        vecs[4].exp_res = 8'd1;   vecs[4].exp_cnt = 8'd1;
        vecs[5].n = 4; vecs[5].a = '{255, 255, 3, 10}; vecs[5].b = '{255, 1, 7, 10};
        vecs[5].exp_res = 8'd121; vecs[5].exp_cnt = 8'd4;

        // Reset state
        repeat (3) @(posedge clock_in);
        #1;
        check("rst state", dbg_state_out, S_FETCH);
        check("rst ready", in_ready_out, 1);
        check("rst valid", result_valid_out, 0);
        check("rst opcode", alu_opcode_out, 8'h00);
        check("rst in1", alu_input1_out, 0);
        check("rst result", result_out, 0);
        check("rst count", result_count_out, 0);
        reset_in = 1'b1;
        @(negedge clock_in);

        // Basic vector with latency / throughput timing
        exp_q.push_back({vecs[0].exp_cnt, vecs[0].exp_res});
        send_pair(2, 3, 1'b0);
        first_acc = accept_cyc;
        send_pair(4, 5, 1'b1);
        check("pair spacing", accept_cyc - first_acc, 3);
        check("lat edge0 valid", result_valid_out, 0);
        @(posedge clock_in); #1;
        check("lat edge1 valid", result_valid_out, 0);
        @(posedge clock_in); #1;
        check("lat edge2 valid", result_valid_out, 1);
        collect("v0");

        // Table-driven vectors
        for (int i = 1; i < 3; i++) begin
            send_vector(vecs[i]);
            collect($sformatf("vec%0d", i));
        end
        send_vector(vecs[5]);
        collect("vec5");

        // Backpressure and enable-gated handshake
        send_vector(vecs[2]);
        while (!result_valid_out) @(negedge clock_in);
        hold_res = result_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_in);
            check("bp valid", result_valid_out, 1);
            check("bp ready", in_ready_out, 0);
            check("bp result", result_out, hold_res);
            check("bp count", result_count_out, 2);
        end
        enable_in = 1'b0; result_ready_in = 1'b1;
        @(posedge clock_in); #1;
        check("stalled handshake valid", result_valid_out, 1);
        check("stalled handshake result", result_out, 8'd244);
        result_ready_in = 1'b0; enable_in = 1'b1;
        collect("bp");
        send_vector(vecs[4]);
        collect("after bp");

        // Enable stall during MUL
        exp_q.push_back({vecs[3].exp_cnt, vecs[3].exp_res});
        send_pair(7, 9, 1'b1);
        enable_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_in);
            check("stall state", dbg_state_out, S_MUL);
            check("stall opcode", alu_opcode_out, 8'h02);
            check("stall in1", alu_input1_out, 7);
            check("stall in2", alu_input2_out, 9);
        end
        enable_in = 1'b1;
        collect("stall");

        // Reset mid-vector
        send_pair(3, 3, 1'b0);
        repeat (2) @(posedge clock_in);
        #1;
        check("partial acc", result_out, 9);
        reset_in = 1'b0;
        #2;
        check("midrst state", dbg_state_out, S_FETCH);
        check("midrst result", result_out, 0);
        check("midrst count", result_count_out, 0);
        check("midrst valid", result_valid_out, 0);
        check("midrst ready", in_ready_out, 1);
        @(negedge clock_in);
        reset_in = 1'b1;
        send_vector(vecs[4]);
        collect("post reset");

        // Idle, then enable low with a pair offered
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_in);
            check("idle state", dbg_state_out, S_FETCH);
            check("idle opcode", alu_opcode_out, 8'h00);
            check("idle in2", alu_input2_out, 0);
            check("idle valid", result_valid_out, 0);
        end
        enable_in = 1'b0; a_in = 8'd5; b_in = 8'd5; in_valid_in = 1'b1;
        #1;
        check("disabled ready", in_ready_out, 0);
        @(posedge clock_in); #1;
        check("disabled no accept", dbg_state_out, S_FETCH);
        in_valid_in = 1'b0; enable_in = 1'b1;

        // Random vectors, expected value from a reference model
        for (int k = 0; k < 4; k++) begin
            rv.n = $urandom_range(1, 4);
            model_acc = 8'd0;
            for (int i = 0; i < 4; i++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rv.a[i] = ra; rv.b[i] = rb;
                if (i < rv.n) model_acc = model_acc + 8'(ra * rb);
            end
            rv.exp_res = model_acc; rv.exp_cnt = 8'(rv.n);
            send_vector(rv);
            collect($sformatf("rand%0d", k));
        end

        // Count wrap: 257 pairs of (1,1)
        exp_q.push_back({8'd1, 8'd1});
        for (int i = 0; i < 257; i++) send_pair(1, 1, i == 256);
        collect("wrap");

        check("queue drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_dot_sequencer.md
# alu_dot_sequencer

Operand sequencer that sits directly upstream of the 8-bit `alu` in the tiny tensor core. It accepts a stream of element pairs, time-multiplexes the single combinational ALU through MUL then ADD opcodes, and accumulates a wrap-around dot product. When the last element arrives, it presents the result and element count on a valid/ready output port.

## Interface
Parameters:
- `DATA_WIDTH`, 8: operand, product and accumulator width; equals the ALU bus width.
- `COUNT_WIDTH`, 8: width of the element counter.

Ports:
- `clock_in`  in  1  single clock; all state updates on its rising edge.
- `reset_in`  in  1  asynchronous, active-low reset.
- `enable_in`  in  1  global advance enable; low = full stall.
- `a_in`  in  DATA_WIDTH  element from vector A.
- `b_in`  in  DATA_WIDTH  element from vector B.
- `in_valid_in`  in  1  element pair valid.
- `in_last_in`  in  1  marks the final pair of a vector.
- `in_ready_out`  out  1  sequencer accepts a pair.
- `alu_opcode_out`  out  8  opcode to the ALU `opcode_in`.
- `alu_input1_out`  out  DATA_WIDTH  drives ALU `alu_input1`.
- `alu_input2_out`  out  DATA_WIDTH  drives ALU `alu_input2`.
- `alu_result_in`  in  DATA_WIDTH  ALU `alu_output`; combinational in the same cycle.
- `result_out`  out  DATA_WIDTH  dot product, mod 2^DATA_WIDTH.
- `result_count_out`  out  COUNT_WIDTH  number of pairs accumulated, mod 2^COUNT_WIDTH.
- `result_valid_out`  out  1  result available.
- `result_ready_in`  in  1  consumer takes the result.

## Operation
FSM states and transitions:
- S_FETCH: `in_ready_out` = `enable_in`. On `in_valid_in && in_ready_out`, latch `a_q`, `b_q` and `last_q`, then go to S_MUL.
- S_MUL: opcode MUL (8'h02), ALU inputs `a_q`, `b_q`. At the edge, `prod_q <= alu_result_in`, then go to S_ADD.
- S_ADD: opcode ADD (8'h00), ALU inputs `acc_q`, `prod_q`. At the edge, `acc_q <= alu_result_in` and `count_q <= count_q + 1`. Go to S_DONE if `last_q`, else S_FETCH.
- S_DONE: `result_valid_out` = 1. On `result_valid_out && result_ready_in`, clear `acc_q` and `count_q` to 0, then go to S_FETCH.

Output rules:
- ALU drive outside S_MUL and S_ADD: opcode ADD, inputs 0.
- `result_out` = `acc_q` and `result_count_out` = `count_q` at all times. They are meaningful only while valid.

Arithmetic:
- All arithmetic is performed by the ALU only: 8-bit truncating multiply and add, so wrap-around is silent.
- No saturation and no overflow flag.
- Counter wraps from 2^COUNT_WIDTH−1 to 0.

Boundary conditions:
- `enable_in` low: every register holds and `in_ready_out` = 0. The result handshake is not consumed, but `result_valid_out` stays high if already asserted. ALU drive keeps the current-state values.
- `in_valid_in` with `in_last_in` on the first pair: valid single-element vector.
- Reset asserted mid-vector: partial accumulation is discarded.

## Timing
Reset values:
- state = S_FETCH.
- `acc_q`, `prod_q`, `count_q`, `a_q`, `b_q`, `last_q` = 0.
- `result_valid_out` = 0, `in_ready_out` = `enable_in`.
- `alu_opcode_out` = 8'h00, ALU inputs 0.

Throughput and latency:
- 3 cycles per element: FETCH, MUL, ADD.
- From the edge accepting the last pair to `result_valid_out` high: 2 edges (MUL, ADD).
- After the result handshake edge, `in_ready_out` is high in the next cycle.

Path and handshake rules:
- `in_ready_out` and `result_valid_out` are decoded from registered state only, with no combinational path from `in_valid_in` or `result_ready_in`.
- `alu_result_in` is sampled on the same edge as the state's exit; the ALU is purely combinational, so no added wait state.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `ALU_OP_ADD`=8'h00, `ALU_OP_SUB`=8'h01, `ALU_OP_MUL`=8'h02, `ALU_OP_EQ`=8'h03, `ALU_OP_GT`=8'h04;
  - `ALU_BUS_WIDTH`=8;
  - the FSM state enum `dot_state_t`.
- No sub-module inside the sequencer. The top-level integration instantiates `alu_dot_sequencer` plus `alu` with `enable_in` tied to the same enable.

## Test plan
- Pairs (2,3),(4,5), last on the second, `result_ready_in`=1 → `result_out`=26 (0x1A), `result_count_out`=2. `result_valid_out` rises 2 edges after the second accept; 6 cycles from first accept to the result-valid cycle.
- Wrap-around: (16,16) single last → 0, count 1. (200,2),(100,1) → (144+100) mod 256 = 244 (0xF4), count 2.
- Backpressure: hold `result_ready_in`=0 for 5 cycles after valid → result, count and valid stable and `in_ready_out`=0. Release → the next vector starts from `acc`=0.
- `enable_in` low for 4 cycles during S_MUL of pair (7,9) → no state change and ALU drive held. Final result 63 is unchanged versus the unstalled run.
- Reset pulsed low after the first pair of (3,3),(5,5) → outputs return to reset values. The subsequent vector (1,1) last yields 1, count 1.
- `in_valid_in` held low for 10 cycles in S_FETCH → nothing accepted, opcode 0x00, inputs 0, `result_valid_out`=0.
